// File: rtl/match_controller.sv
// Top-level match sequencer for two-player foosball: serve countdown, play, goals,
// pause and game-over, with both scores, multi-ball count and winner.
module match_controller #(
  parameter int unsigned MAX_GOALS   = 9,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned NUM_BALLS   = 2,
  parameter int unsigned SERVE_TICKS = 3
) (
  input  logic                               CLK,
  input  logic                               RESETn,
  input  logic                               space,
  input  logic                               pause_key,
  input  logic                               tick,
  input  logic                               goal_p1,
  input  logic                               goal_p2,
  input  logic                               multi_req,
  output logic [2:0]                         state_o,
  output logic                               move,
  output logic [SCORE_W-1:0]                 score_p1,
  output logic [SCORE_W-1:0]                 score_p2,
  output logic [$clog2(NUM_BALLS+1)-1:0]     balls_active,
  output logic [$clog2(SERVE_TICKS+1)-1:0]   serve_cnt,
  output logic [1:0]                         winner
);

  localparam int unsigned BALL_W = $clog2(NUM_BALLS + 1);
  localparam int unsigned CNT_W  = $clog2(SERVE_TICKS + 1);

  localparam logic [SCORE_W-1:0] MAX_SCORE  = SCORE_W'(MAX_GOALS);
  localparam logic [BALL_W-1:0]  MAX_BALLS  = BALL_W'(NUM_BALLS);
  localparam logic [BALL_W-1:0]  ONE_BALL   = BALL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic                 ret_serve, ret_serve_nxt;
  logic [SCORE_W-1:0]   score_p1_nxt, score_p2_nxt;
  logic [SCORE_W-1:0]   score_p1_inc, score_p2_inc;
  logic [BALL_W-1:0]    balls_nxt;
  logic [CNT_W-1:0]     serve_cnt_nxt;
  logic [1:0]           winner_nxt;
  logic                 space_q, pause_q, armed;
  logic                 space_e, pause_e;

  // armed stays low for the first edge after reset so a key held through reset gives no edge
  assign space_e = space & ~space_q & armed;
  assign pause_e = pause_key & ~pause_q & armed;

  assign state_o = state;
  assign move    = (state == PLAY);

  assign score_p1_inc = (score_p1 < MAX_SCORE) ? score_p1 + SCORE_W'(1) : score_p1;
  assign score_p2_inc = (score_p2 < MAX_SCORE) ? score_p2 + SCORE_W'(1) : score_p2;

  // State and match bookkeeping registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state        <= IDLE;
      ret_serve    <= 1'b0;
      score_p1     <= '0;
      score_p2     <= '0;
      balls_active <= ONE_BALL;
      serve_cnt    <= '0;
      winner       <= 2'd0;
      space_q      <= 1'b0;
      pause_q      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      state        <= state_nxt;
      ret_serve    <= ret_serve_nxt;
      score_p1     <= score_p1_nxt;
      score_p2     <= score_p2_nxt;
      balls_active <= balls_nxt;
      serve_cnt    <= serve_cnt_nxt;
      winner       <= winner_nxt;
      space_q      <= space;
      pause_q      <= pause_key;
      armed        <= 1'b1;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt     = state;
    ret_serve_nxt = ret_serve;
    score_p1_nxt  = score_p1;
    score_p2_nxt  = score_p2;
    balls_nxt     = balls_active;
    serve_cnt_nxt = serve_cnt;
    winner_nxt    = winner;

    case (state)
      IDLE: begin
        if (space_e) begin
          state_nxt     = SERVE;
          serve_cnt_nxt = CNT_INIT;
          score_p1_nxt  = '0;
          score_p2_nxt  = '0;
          balls_nxt     = ONE_BALL;
          winner_nxt    = 2'd0;
        end
      end

      SERVE: begin
        if (pause_e) begin
          state_nxt     = PAUSE;
          ret_serve_nxt = 1'b1;
        end else if (tick) begin
          if (serve_cnt <= CNT_ONE) begin
            state_nxt     = PLAY;
            serve_cnt_nxt = '0;
          end else begin
            serve_cnt_nxt = serve_cnt - CNT_ONE;
          end
        end
      end

      PLAY: begin
        if (goal_p1 || goal_p2) begin
          score_p1_nxt = goal_p1 ? score_p1_inc : score_p1;
          score_p2_nxt = goal_p2 ? score_p2_inc : score_p2;
          balls_nxt    = ONE_BALL;
          if ((score_p1_nxt == MAX_SCORE) || (score_p2_nxt == MAX_SCORE)) begin
            state_nxt  = OVER;
            winner_nxt = {score_p2_nxt == MAX_SCORE, score_p1_nxt == MAX_SCORE};
          end else begin
            state_nxt  = GOAL;
          end
        end else if (pause_e) begin
          state_nxt     = PAUSE;
          ret_serve_nxt = 1'b0;
        end else if (multi_req && (balls_active < MAX_BALLS)) begin
          balls_nxt = balls_active + ONE_BALL;
        end
      end

      GOAL: begin
        if (space_e) begin
          state_nxt     = SERVE;
          serve_cnt_nxt = CNT_INIT;
        end
      end

      PAUSE: begin
        if (pause_e) begin
          state_nxt = ret_serve ? SERVE : PLAY;
        end
      end

      OVER: begin
        if (space_e) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_match_controller.sv
// Vector-table bench for match_controller: expected outputs are queued when a vector
// is driven and compared by a monitor after the clock edge that consumes it.
module tb_match_controller;

  localparam int unsigned SW = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GOAL  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  typedef struct packed {
    logic [2:0]    st;
    logic          mv;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    logic [1:0]    w;
  } out_t;

  typedef struct {
    logic sp, pk, tk, g1, g2, mr;
    out_t exp;
  } vec_t;

  typedef struct {
    int   id;
    out_t exp;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          space, pause_key, tick, goal_p1, goal_p2, multi_req;
  logic [2:0]    state_o;
  logic          move;
  logic [SW-1:0] score_p1, score_p2;
  logic [BW-1:0] balls_active;
  logic [CW-1:0] serve_cnt;
  logic [1:0]    winner;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  match_controller #(
    .MAX_GOALS  (3),
    .SCORE_W    (4),
    .NUM_BALLS  (2),
    .SERVE_TICKS(2)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .space       (space),
    .pause_key   (pause_key),
    .tick        (tick),
    .goal_p1     (goal_p1),
    .goal_p2     (goal_p2),
    .multi_req   (multi_req),
    .state_o     (state_o),
    .move        (move),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .balls_active(balls_active),
    .serve_cnt   (serve_cnt),
    .winner      (winner)
  );

  always #5 CLK = ~CLK;

  function automatic out_t mk_out(input logic [2:0] st, input int s1, input int s2,
                                  input int b, input int c, input int w);
    out_t o;
    o.st = st;
    o.mv = (st == S_PLAY);
    o.s1 = SW'(s1);
    o.s2 = SW'(s2);
    o.b  = BW'(b);
    o.c  = CW'(c);
    o.w  = 2'(w);
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.st = state_o;
    o.mv = move;
    o.s1 = score_p1;
    o.s2 = score_p2;
    o.b  = balls_active;
    o.c  = serve_cnt;
    o.w  = winner;
    return o;
  endfunction

  task automatic check(input string name, input out_t want);
    out_t got;
    got = get_out();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got st=%0d mv=%0d s1=%0d s2=%0d balls=%0d cnt=%0d win=%0d, want st=%0d mv=%0d s1=%0d s2=%0d balls=%0d cnt=%0d win=%0d",
               name, got.st, got.mv, got.s1, got.s2, got.b, got.c, got.w,
               want.st, want.mv, want.s1, want.s2, want.b, want.c, want.w);
    end
  endtask

  task automatic add(input logic sp, input logic pk, input logic tk, input logic g1,
                     input logic g2, input logic mr, input logic [2:0] st,
                     input int s1, input int s2, input int b, input int c, input int w);
    vec_t v;
    v.sp = sp; v.pk = pk; v.tk = tk; v.g1 = g1; v.g2 = g2; v.mr = mr;
    v.exp = mk_out(st, s1, s2, b, c, w);
    tbl.push_back(v);
  endtask

  // Start/continue press followed by a full countdown into PLAY
  task automatic serve(input int s1, input int s2);
    add(1, 0, 0, 0, 0, 0, S_SERVE, s1, s2, 1, 2, 0);
    add(0, 0, 1, 0, 0, 0, S_SERVE, s1, s2, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, S_PLAY,  s1, s2, 1, 0, 0);
  endtask

  task automatic drive(input logic sp, input logic pk, input logic tk, input logic g1,
                       input logic g2, input logic mr);
    space = sp; pause_key = pk; tick = tk; goal_p1 = g1; goal_p2 = g2; multi_req = mr;
  endtask

  // Monitor: compare the oldest queued expectation just after each active edge
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d", e.id), e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Player 1 wins 3-0; goal and pause in GOAL ignored; OVER holds then returns to IDLE
    add(1, 0, 0, 0, 0, 0, S_SERVE, 0, 0, 1, 2, 0);
    add(0, 0, 1, 0, 0, 0, S_SERVE, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, S_PLAY,  0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, S_GOAL,  1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, S_GOAL,  1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, S_GOAL,  1, 0, 1, 0, 0);
    serve(1, 0);
    add(0, 0, 0, 1, 0, 0, S_GOAL,  2, 0, 1, 0, 0);
    serve(2, 0);
    add(0, 0, 0, 1, 0, 0, S_OVER,  3, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, S_OVER,  3, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, S_IDLE,  3, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, S_IDLE,  3, 0, 1, 0, 1);
    // Draw: 2/2 then simultaneous goals
    serve(0, 0);
    add(0, 0, 0, 1, 0, 0, S_GOAL,  1, 0, 1, 0, 0);
    serve(1, 0);
    add(0, 0, 0, 0, 1, 0, S_GOAL,  1, 1, 1, 0, 0);
    serve(1, 1);
    add(0, 0, 0, 1, 0, 0, S_GOAL,  2, 1, 1, 0, 0);
    serve(2, 1);
    add(0, 0, 0, 0, 1, 0, S_GOAL,  2, 2, 1, 0, 0);
    serve(2, 2);
    add(0, 0, 0, 1, 1, 0, S_OVER,  3, 3, 1, 0, 3);
    add(1, 0, 0, 0, 0, 0, S_IDLE,  3, 3, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, S_IDLE,  3, 3, 1, 0, 3);
    // Multi-ball saturation and reset on goal
    serve(0, 0);
    add(0, 0, 0, 0, 0, 1, S_PLAY,  0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, S_PLAY,  0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, S_PLAY,  0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, S_GOAL,  0, 1, 1, 0, 0);
    serve(0, 1);
    add(0, 0, 0, 0, 0, 1, S_PLAY,  0, 1, 2, 0, 0);
    add(0, 0, 0, 1, 0, 1, S_GOAL,  1, 1, 1, 0, 0);
    // Pause during the serve countdown
    add(1, 0, 0, 0, 0, 0, S_SERVE, 1, 1, 1, 2, 0);
    add(0, 0, 1, 0, 0, 0, S_SERVE, 1, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, S_PAUSE, 1, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, S_PAUSE, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, S_PAUSE, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, S_PAUSE, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, S_PAUSE, 1, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, S_SERVE, 1, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, S_PLAY,  1, 1, 1, 0, 0);
    // Pause during play, then goal beats pause
    add(0, 0, 0, 0, 0, 1, S_PLAY,  1, 1, 2, 0, 0);
    add(0, 1, 0, 0, 0, 0, S_PAUSE, 1, 1, 2, 0, 0);
    add(0, 0, 1, 0, 0, 0, S_PAUSE, 1, 1, 2, 0, 0);
    add(0, 1, 0, 0, 0, 1, S_PLAY,  1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, S_PLAY,  1, 1, 2, 0, 0);
    add(0, 1, 0, 1, 0, 0, S_GOAL,  2, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, S_GOAL,  2, 1, 1, 0, 0);
    serve(2, 1);

    // Key held high through reset release must not start a match
    RESETn = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    check("reset_state", mk_out(S_IDLE, 0, 0, 1, 0, 0));
    RESETn = 1'b1;
    repeat (3) @(negedge CLK);
    check("space_held_reset", mk_out(S_IDLE, 0, 0, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      drive(tbl[i].sp, tbl[i].pk, tbl[i].tk, tbl[i].g1, tbl[i].g2, tbl[i].mr);
      e.id  = i;
      e.exp = tbl[i].exp;
      exp_q.push_back(e);
      @(negedge CLK);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    // Asynchronous reset in PLAY at 2/1 clears outputs without a clock edge
    check("before_reset_play", mk_out(S_PLAY, 2, 1, 1, 0, 0));
    RESETn = 1'b0;
    #1;
    check("async_reset_mid_play", mk_out(S_IDLE, 0, 0, 1, 0, 0));
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    check("after_reset_release", mk_out(S_IDLE, 0, 0, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
